// File: rtl/lenet_run_ctrl.sv
// lenet_run_ctrl: sequences one camera -> LeNet -> display run.
//   A button press shows the capture box (bound_doing) for BOUND_FRAMES frames.
//   It then pulses lenet_start and waits for a rising edge on lenet_ready,
//   shows the digit overlay (lenet_doing) for SHOW_FRAMES frames, and returns
//   to live video. Frames are counted on the leading edge of vga_vsync.
// Ports:
//   clk24        in  pixel clock (same clock as the VGA block)
//   rst_n        in  asynchronous reset, active low
//   btn          in  start button, asynchronous level, already debounced
//   vga_vsync    in  registered vsync from the VGA block
//   lenet_ready  in  LeNet result valid (level or pulse)
//   lenet_start  out one-cycle pulse: begin sampling + inference
//   bound_doing  out show capture box
//   lenet_doing  out show digit overlay
//   busy         out controller is not idle
//   timeout_err  out sticky: last run aborted waiting for lenet_ready
module lenet_run_ctrl #(
    parameter logic        VSYNC_ACTIVE   = 1'b0,
    parameter int unsigned BOUND_FRAMES   = 60,
    parameter int unsigned SHOW_FRAMES    = 120,
    parameter int unsigned TIMEOUT_FRAMES = 30,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk24,
    input  logic rst_n,
    input  logic btn,
    input  logic vga_vsync,
    input  logic lenet_ready,
    output logic lenet_start,
    output logic bound_doing,
    output logic lenet_doing,
    output logic busy,
    output logic timeout_err
);

    localparam logic [CNT_W-1:0] BOUND_LAST   = CNT_W'(BOUND_FRAMES);
    localparam logic [CNT_W-1:0] SHOW_LAST    = CNT_W'(SHOW_FRAMES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOUND = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SHOW  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_nxt_terr;

    logic r_btn_s1;
    logic r_btn_s2;
    logic r_btn_s3;
    logic r_vsync_q;
    logic r_ready_q;

    logic w_press;
    logic w_frame;
    logic w_ready_rise;

    // Event detectors: synchronized button edge, vsync leading edge, ready edge.
    assign w_press      = r_btn_s2 & ~r_btn_s3;
    assign w_frame      = (vga_vsync == VSYNC_ACTIVE) & (r_vsync_q != VSYNC_ACTIVE);
    assign w_ready_rise = lenet_ready & ~r_ready_q;
    assign w_cnt_inc    = r_frame_cnt + CNT_W'(1);

    // Next-state / frame counter / sticky error decode.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_frame_cnt;
        w_nxt_terr  = timeout_err;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_nxt_state = ST_BOUND;
                    w_nxt_cnt   = '0;
                    w_nxt_terr  = 1'b0;
                end
            end
            ST_BOUND: begin
                if (w_frame) begin
                    w_nxt_cnt = w_cnt_inc;
                    if (w_cnt_inc == BOUND_LAST) w_nxt_state = ST_START;
                end
            end
            ST_START: begin
                w_nxt_state = ST_WAIT;
                w_nxt_cnt   = '0;
            end
            ST_WAIT: begin
                // A ready edge beats a timeout frame arriving in the same cycle.
                if (w_ready_rise) begin
                    w_nxt_state = ST_SHOW;
                    w_nxt_cnt   = '0;
                end else if (w_frame) begin
                    w_nxt_cnt = w_cnt_inc;
                    if (w_cnt_inc == TIMEOUT_LAST) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_terr  = 1'b1;
                    end
                end
            end
            ST_SHOW: begin
                // A re-press restarts the run and beats a frame in the same cycle.
                if (w_press) begin
                    w_nxt_state = ST_BOUND;
                    w_nxt_cnt   = '0;
                end else if (w_frame) begin
                    w_nxt_cnt = w_cnt_inc;
                    if (w_cnt_inc == SHOW_LAST) w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State, synchronizers and outputs; outputs are decoded from the next state
    // so they change on the same edge as the state register.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_s3    <= 1'b0;
            r_vsync_q   <= ~VSYNC_ACTIVE;
            r_ready_q   <= 1'b0;
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            lenet_start <= 1'b0;
            bound_doing <= 1'b0;
            lenet_doing <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_btn_s1    <= btn;
            r_btn_s2    <= r_btn_s1;
            r_btn_s3    <= r_btn_s2;
            r_vsync_q   <= vga_vsync;
            r_ready_q   <= lenet_ready;
            r_state     <= w_nxt_state;
            r_frame_cnt <= w_nxt_cnt;
            lenet_start <= (w_nxt_state == ST_START);
            bound_doing <= (w_nxt_state == ST_BOUND) || (w_nxt_state == ST_START)
                        || (w_nxt_state == ST_WAIT);
            lenet_doing <= (w_nxt_state == ST_SHOW);
            busy        <= (w_nxt_state != ST_IDLE);
            timeout_err <= w_nxt_terr;
        end
    end

endmodule

// File: tb/tb_lenet_run_ctrl.sv
// tb_lenet_run_ctrl: directed bench for lenet_run_ctrl with short frames.
//   Output vector order in checks: {lenet_start, bound_doing, lenet_doing, busy, timeout_err}.
module tb_lenet_run_ctrl;

    logic clk24;
    logic rst_n;
    logic btn;
    logic vga_vsync;
    logic lenet_ready;
    logic lenet_start;
    logic bound_doing;
    logic lenet_doing;
    logic busy;
    logic timeout_err;

    logic [4:0] outs;
    int         n_checks;
    int         n_fail;
    int         n_start;
    logic       prev_start;

    assign outs = {lenet_start, bound_doing, lenet_doing, busy, timeout_err};

    lenet_run_ctrl #(
        .VSYNC_ACTIVE  (1'b0),
        .BOUND_FRAMES  (2),
        .SHOW_FRAMES   (3),
        .TIMEOUT_FRAMES(2),
        .CNT_W         (8)
    ) dut (
        .clk24      (clk24),
        .rst_n      (rst_n),
        .btn        (btn),
        .vga_vsync  (vga_vsync),
        .lenet_ready(lenet_ready),
        .lenet_start(lenet_start),
        .bound_doing(bound_doing),
        .lenet_doing(lenet_doing),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk24 = 1'b0;
    always #5 clk24 = ~clk24;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and check per-cycle invariants.
    task automatic tick();
        @(posedge clk24);
        #1;
        chk("excl", 32'(bound_doing & lenet_doing), 32'd0);
        chk("start_width", 32'(lenet_start & prev_start), 32'd0);
        if (lenet_start === 1'b1) n_start++;
        prev_start = lenet_start;
    endtask

    task automatic frame_edge();
        vga_vsync = 1'b0;
        tick();
    endtask

    task automatic frame_tail();
        tick();
        vga_vsync = 1'b1;
        repeat (6) tick();
    endtask

    // Press from idle-like state; checks the two-cycle synchronizer latency.
    task automatic press(input string tag, input logic [4:0] before_exp);
        btn = 1'b1;
        tick();
        tick();
        chk({tag, "_pre"}, 32'(outs), 32'(before_exp));
        tick();
        chk({tag, "_bound"}, 32'(outs), 32'(5'b01010));
    endtask

    // From fresh BOUND: two box frames, start pulse, two WAIT frames, timeout.
    task automatic bound_to_timeout(input string tag);
        frame_edge(); chk({tag, "_bf1"}, 32'(outs), 32'(5'b01010)); frame_tail();
        frame_edge(); chk({tag, "_start"}, 32'(outs), 32'(5'b11010)); frame_tail();
        frame_edge(); chk({tag, "_wf1"}, 32'(outs), 32'(5'b01010)); frame_tail();
        frame_edge(); chk({tag, "_tmo"}, 32'(outs), 32'(5'b00001)); frame_tail();
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        n_start     = 0;
        prev_start  = 1'b0;
        rst_n       = 1'b0;
        btn         = 1'b0;
        vga_vsync   = 1'b1;
        lenet_ready = 1'b0;

        // Test 1: reset, then idle through 5 frames.
        repeat (3) tick();
        chk("t1_reset", 32'(outs), 32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            frame_edge();
            chk("t1_idle", 32'(outs), 32'd0);
            frame_tail();
        end

        // Test 2: full run with ready ~100 cycles after the start pulse.
        n_start = 0;
        press("t2", 5'b00000);
        btn = 1'b0;
        frame_edge(); chk("t2_bf1", 32'(outs), 32'(5'b01010)); frame_tail();
        frame_edge(); chk("t2_start", 32'(outs), 32'(5'b11010));
        tick();       chk("t2_wait", 32'(outs), 32'(5'b01010));
        vga_vsync = 1'b1;
        repeat (98) tick();
        chk("t2_wait_long", 32'(outs), 32'(5'b01010));
        lenet_ready = 1'b1;
        tick();       chk("t2_show", 32'(outs), 32'(5'b00110));
        lenet_ready = 1'b0;
        frame_edge(); chk("t2_sf1", 32'(outs), 32'(5'b00110)); frame_tail();
        frame_edge(); chk("t2_sf2", 32'(outs), 32'(5'b00110)); frame_tail();
        frame_edge(); chk("t2_idle", 32'(outs), 32'(5'b00000)); frame_tail();
        chk("t2_nstart", 32'(n_start), 32'd1);

        // Test 3: no ready -> timeout; next press clears timeout_err on BOUND entry.
        press("t3a", 5'b00000);
        btn = 1'b0;
        bound_to_timeout("t3a");
        press("t3b", 5'b00001);
        btn = 1'b0;
        bound_to_timeout("t3b");

        // Test 4: btn held across a whole run, ready pulse during BOUND ignored.
        n_start = 0;
        press("t4", 5'b00001);
        lenet_ready = 1'b1;
        tick();
        lenet_ready = 1'b0;
        tick();
        chk("t4_rdy_ign", 32'(outs), 32'(5'b01010));
        bound_to_timeout("t4");
        repeat (10) tick();
        chk("t4_no_rerun", 32'(outs), 32'(5'b00001));
        chk("t4_nstart", 32'(n_start), 32'd1);
        btn = 1'b0;
        repeat (3) tick();

        // Test 5: ready edge coincides with timeout frame; re-press during SHOW.
        press("t5", 5'b00001);
        btn = 1'b0;
        frame_edge(); chk("t5_bf1", 32'(outs), 32'(5'b01010)); frame_tail();
        frame_edge(); chk("t5_start", 32'(outs), 32'(5'b11010)); frame_tail();
        frame_edge(); chk("t5_wf1", 32'(outs), 32'(5'b01010)); frame_tail();
        vga_vsync   = 1'b0;
        lenet_ready = 1'b1;
        tick();
        chk("t5_race_show", 32'(outs), 32'(5'b00110));
        lenet_ready = 1'b0;
        frame_tail();
        press("t5_rerun", 5'b00110);
        btn = 1'b0;

        // Test 6: asynchronous reset while in WAIT.
        frame_edge(); chk("t6_bf1", 32'(outs), 32'(5'b01010)); frame_tail();
        frame_edge(); chk("t6_start", 32'(outs), 32'(5'b11010)); frame_tail();
        chk("t6_wait", 32'(outs), 32'(5'b01010));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", 32'(outs), 32'd0);
        tick();
        rst_n = 1'b1;
        n_start = 0;
        tick();
        chk("t6_after_rst", 32'(outs), 32'd0);
        for (int i = 0; i < 3; i++) begin
            frame_edge();
            chk("t6_idle", 32'(outs), 32'd0);
            frame_tail();
        end
        chk("t6_nstart", 32'(n_start), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
